// File: rtl/sar_search_ctrl_if.sv
// Bundle between the successive-approximation search controller and its environment
// (requester plus external comparator).
//   start            : request a new search (sampled only while the controller is idle)
//   greater/equal/smaller : comparator flags for hidden target vs. probe
//   probe            : value driven onto the comparator b input
//   busy, done       : search in progress / one-cycle completion pulse
//   result, exact    : search result and whether equality was seen
//   cmp_err          : comparator flags were not one-hot, search aborted
//   steps            : number of probes issued by the last search
// master = controller side, slave = requester/comparator side.
interface sar_search_ctrl_if #(
   parameter int unsigned CMP_WIDTH = 4
);
   localparam int unsigned StepsW = $clog2(CMP_WIDTH + 1);

   logic                 start;
   logic                 greater;
   logic                 equal;
   logic                 smaller;
   logic [CMP_WIDTH-1:0] probe;
   logic                 busy;
   logic                 done;
   logic [CMP_WIDTH-1:0] result;
   logic                 exact;
   logic                 cmp_err;
   logic [StepsW-1:0]    steps;

   modport master (
      input  start, greater, equal, smaller,
      output probe, busy, done, result, exact, cmp_err, steps
   );

   modport slave (
      output start, greater, equal, smaller,
      input  probe, busy, done, result, exact, cmp_err, steps
   );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller. Presents one registered probe per clock to
// an external combinational comparator and binary-searches the hidden target, MSB first.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sar_search_ctrl_if.master (start, comparator flags in; probe, busy, done,
//           result, exact, cmp_err, steps out)
module sar_search_ctrl #(
   parameter int unsigned CMP_WIDTH = 4
) (
   input logic               clk,
   input logic               rst_n,
   sar_search_ctrl_if.master bus
);
   localparam int unsigned StepsW = $clog2(CMP_WIDTH + 1);
   localparam int unsigned IdxW   = (CMP_WIDTH > 1) ? $clog2(CMP_WIDTH) : 1;

   typedef logic [CMP_WIDTH-1:0] word_t;
   typedef logic [IdxW-1:0]      idx_t;
   typedef logic [StepsW-1:0]    steps_t;

   localparam idx_t   IdxTop   = idx_t'(CMP_WIDTH - 1);
   localparam word_t  ProbeMsb = word_t'(1) << (CMP_WIDTH - 1);
   localparam steps_t StepsMax = steps_t'(CMP_WIDTH);

   typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

   state_e state_q, state_d;
   word_t  probe_q, probe_d;
   word_t  acc_q, acc_d;
   idx_t   idx_q, idx_d;
   word_t  result_q, result_d;
   logic   exact_q, exact_d;
   logic   err_q, err_d;
   steps_t steps_q, steps_d;
   word_t  acc_new;
   logic   flags_ok;

   always_comb begin
      state_d  = state_q;
      probe_d  = probe_q;
      acc_d    = acc_q;
      idx_d    = idx_q;
      result_d = result_q;
      exact_d  = exact_q;
      err_d    = err_q;
      steps_d  = steps_q;
      acc_new  = acc_q;
      flags_ok = $onehot({bus.greater, bus.equal, bus.smaller});

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               result_d = '0;
               exact_d  = 1'b0;
               err_d    = 1'b0;
               steps_d  = '0;
               acc_d    = '0;
               probe_d  = ProbeMsb;
               idx_d    = IdxTop;
               state_d  = StSearch;
            end
         end
         StSearch: begin
            if (steps_q != StepsMax) begin
               steps_d = steps_q + steps_t'(1);
            end
            if (!flags_ok) begin
               // Untrustworthy comparator: report only the bits already settled.
               err_d    = 1'b1;
               exact_d  = 1'b0;
               result_d = acc_q;
               probe_d  = '0;
               state_d  = StDone;
            end else if (bus.equal) begin
               result_d = probe_q;
               exact_d  = 1'b1;
               probe_d  = '0;
               state_d  = StDone;
            end else begin
               // Target above probe: the trial bit belongs to the answer.
               if (bus.greater) begin
                  acc_new = probe_q;
               end
               acc_d = acc_new;
               if (idx_q == '0) begin
                  result_d = acc_new;
                  exact_d  = 1'b0;
                  probe_d  = '0;
                  state_d  = StDone;
               end else begin
                  probe_d = acc_new | (word_t'(1) << (idx_q - idx_t'(1)));
                  idx_d   = idx_q - idx_t'(1);
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         probe_q  <= '0;
         acc_q    <= '0;
         idx_q    <= IdxTop;
         result_q <= '0;
         exact_q  <= 1'b0;
         err_q    <= 1'b0;
         steps_q  <= '0;
      end else begin
         state_q  <= state_d;
         probe_q  <= probe_d;
         acc_q    <= acc_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         exact_q  <= exact_d;
         err_q    <= err_d;
         steps_q  <= steps_d;
      end
   end

   assign bus.probe   = probe_q;
   assign bus.busy    = (state_q == StSearch);
   assign bus.done    = (state_q == StDone);
   assign bus.result  = result_q;
   assign bus.exact   = exact_q;
   assign bus.cmp_err = err_q;
   assign bus.steps   = steps_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Self-checking bench for sar_search_ctrl (CMP_WIDTH = 4). The comparator is modelled
// from a target register; a force path injects non-one-hot flags on a chosen probe.
module tb_sar_search_ctrl;
   localparam int W = 4;

   logic       clk;
   logic       rst_n;
   logic       start;
   int         target;
   logic       force_en;
   logic [2:0] force_flags;
   int         n_cmp;
   int         n_bad;

   sar_search_ctrl_if #(.CMP_WIDTH(W)) bus ();

   assign bus.start   = start;
   assign bus.greater = force_en ? force_flags[2] : (target > int'(bus.probe));
   assign bus.equal   = force_en ? force_flags[1] : (target == int'(bus.probe));
   assign bus.smaller = force_en ? force_flags[0] : (target < int'(bus.probe));

   sar_search_ctrl #(.CMP_WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int tgt;
      int err_at;
      int e_res;
      int e_exact;
      int e_err;
      int e_steps;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Probes needed: a nonzero target is hit once the probe reaches its lowest set bit.
   function automatic int model_steps(input int t);
      int s = W;
      for (int b = W - 1; b >= 0; b--) begin
         if (((t >> b) & 1) != 0) s = W - b;
      end
      return s;
   endfunction

   // k-th probe: the target's bits above trial position W-k, plus the trial bit.
   function automatic int model_probe(input int t, input int k);
      int pos = W - k;
      return ((t >> (pos + 1)) << (pos + 1)) | (1 << pos);
   endfunction

   task automatic check_outputs_zero(input string tag);
      check({tag, " busy"},    32'(bus.busy),    0);
      check({tag, " done"},    32'(bus.done),    0);
      check({tag, " probe"},   32'(bus.probe),   0);
      check({tag, " result"},  32'(bus.result),  0);
      check({tag, " exact"},   32'(bus.exact),   0);
      check({tag, " cmp_err"}, 32'(bus.cmp_err), 0);
      check({tag, " steps"},   32'(bus.steps),   0);
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_search(input string tag, input int tgt, input int err_at,
                             input int e_res, input int e_exact, input int e_err,
                             input int e_steps);
      int busy_cnt = 0;
      @(negedge clk);
      target = tgt;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      while (bus.busy && busy_cnt < W + 2) begin
         busy_cnt++;
         check($sformatf("%s probe%0d", tag, busy_cnt), 32'(bus.probe),
               32'(model_probe(tgt, busy_cnt)));
         if (busy_cnt == err_at) begin
            force_en    = 1'b1;
            force_flags = 3'b110;
         end
         @(negedge clk);
         force_en = 1'b0;
      end
      check({tag, " done"},     32'(bus.done),    1);
      check({tag, " busy_cyc"}, 32'(busy_cnt),    32'(e_steps));
      check({tag, " result"},   32'(bus.result),  32'(e_res));
      check({tag, " exact"},    32'(bus.exact),   32'(e_exact));
      check({tag, " cmp_err"},  32'(bus.cmp_err), 32'(e_err));
      check({tag, " steps"},    32'(bus.steps),   32'(e_steps));
      check({tag, " probe0"},   32'(bus.probe),   0);
      @(negedge clk);
      check({tag, " done_1cyc"}, 32'(bus.done),   0);
      check({tag, " held"},      32'(bus.result), 32'(e_res));
   endtask

   vec_t vecs[$];

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      start       = 1'b0;
      target      = 0;
      force_en    = 1'b0;
      force_flags = 3'b000;
      rst_n       = 1'b0;

      //            tgt err  res exact err steps
      vecs.push_back('{11, 0, 11, 1, 0, 4});
      vecs.push_back('{12, 0, 12, 1, 0, 2});
      vecs.push_back('{ 0, 0,  0, 0, 0, 4});
      vecs.push_back('{15, 0, 15, 1, 0, 4});
      vecs.push_back('{ 5, 2,  0, 0, 1, 2});
      vecs.push_back('{ 5, 0,  5, 1, 0, 4});
      vecs.push_back('{ 8, 0,  8, 1, 0, 1});
      vecs.push_back('{ 1, 0,  1, 1, 0, 4});
      vecs.push_back('{ 9, 1,  0, 0, 1, 1});
      vecs.push_back('{14, 3, 12, 0, 1, 3});

      #12;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs_zero("post_reset");

      foreach (vecs[i]) begin
         run_search($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].err_at, vecs[i].e_res,
                    vecs[i].e_exact, vecs[i].e_err, vecs[i].e_steps);
      end

      // Start held high: one search every steps+2 cycles; start during busy/done ignored.
      @(negedge clk);
      target = 6;
      start  = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         int ph;
         @(negedge clk);
         ph = c % (model_steps(6) + 2);
         check($sformatf("b2b busy c%0d", c), 32'(bus.busy),
               32'(ph >= 1 && ph <= model_steps(6)));
         check($sformatf("b2b done c%0d", c), 32'(bus.done), 32'(ph == model_steps(6) + 1));
         if (ph == model_steps(6) + 1) begin
            check($sformatf("b2b result c%0d", c), 32'(bus.result), 6);
         end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("b2b idle", 32'(bus.busy | bus.done), 0);

      // Reset asserted during the third probe of a search.
      target = 11;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_mid probe3", 32'(bus.probe), 10);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("rst_mid");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("rst_mid no_done%0d", c), 32'(bus.done), 0);
      end
      rst_n = 1'b1;
      run_search("after_rst", 11, 0, 11, 1, 0, 4);

      // Randomized targets with occasional flag corruption, checked against the model.
      for (int r = 0; r < 25; r++) begin
         int t, n, ea;
         t  = int'($urandom_range(0, 15));
         n  = model_steps(t);
         ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
         if (ea != 0) begin
            run_search($sformatf("rnd%0d", r), t, ea,
                       (t >> (W - ea + 1)) << (W - ea + 1), 0, 1, ea);
         end else begin
            run_search($sformatf("rnd%0d", r), t, 0, t, (t != 0) ? 1 : 0, 0, n);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
